// File: rtl/shift_ser_pkg.sv
// shift_ser_pkg: shared types and constants for the shift/add result serializer.
// SHIFT_SER_CHECKSUM_EN selects the 4-beat frame (checksum beat last) instead of 3 beats.
package shift_ser_pkg;

    // One state per output beat plus the idle/accept state.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B0   = 3'd1,
        B1   = 3'd2,
        B2   = 3'd3,
        BCHK = 3'd4
    } ser_state_e;

    // Beat index values driven on OUT_SEL.
    localparam logic [1:0] SEL_B0  = 2'd0;
    localparam logic [1:0] SEL_B1  = 2'd1;
    localparam logic [1:0] SEL_B2  = 2'd2;
    localparam logic [1:0] SEL_CHK = 2'd3;

    // State that carries the final beat of a frame; OUT_LAST is raised while in it.
`ifdef SHIFT_SER_CHECKSUM_EN
    localparam ser_state_e LAST_BEAT = BCHK;
`else
    localparam ser_state_e LAST_BEAT = B2;
`endif

    // Beat index presented while the FSM sits in a given state (IDLE reads as 0).
    function automatic logic [1:0] state_sel(input ser_state_e s);
        case (s)
            B1:      return SEL_B1;
            B2:      return SEL_B2;
            BCHK:    return SEL_CHK;
            default: return SEL_B0;
        endcase
    endfunction

endpackage

// File: rtl/shift_result_serializer.sv
// shift_result_serializer: captures the three shift/add results (A>>2, B<<2, A+B) as one frame
// and streams them out one beat per valid/ready transfer, counting completed frames.
// Define SHIFT_SER_CHECKSUM_EN to append a fourth beat carrying IN1^IN2^IN3 (OUT_SEL = 3).
module shift_result_serializer
    import shift_ser_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH:0]   IN1,
    input  logic [WIDTH:0]   IN2,
    input  logic [WIDTH:0]   IN3,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH:0]   OUT_DATA,
    output logic [1:0]       OUT_SEL,
    output logic             OUT_LAST,
    output logic [CNT_W-1:0] FRAME_CNT
);

    ser_state_e state_q, state_d;

    // Beat 0 goes straight into the output register at capture, so only the
    // later beats need holding registers.
    logic [WIDTH:0] in2_q, in2_d;
    logic [WIDTH:0] in3_q, in3_d;
`ifdef SHIFT_SER_CHECKSUM_EN
    logic [WIDTH:0] chk_q, chk_d;
`endif

    logic             out_valid_q, out_valid_d;
    logic [WIDTH:0]   out_data_q, out_data_d;
    logic [1:0]       out_sel_q, out_sel_d;
    logic             out_last_q, out_last_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic beat_xfer;
    logic frame_done;

    assign beat_xfer = out_valid_q && OUT_READY;

    // Only IDLE accepts; reset blocks acceptance combinationally.
    assign IN_READY  = (state_q == IDLE) && !RST;

    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_SEL   = out_sel_q;
    assign OUT_LAST  = out_last_q;
    assign FRAME_CNT = frame_cnt_q;

    // Next-state, frame capture and next output beat selection.
    always_comb begin
        state_d     = state_q;
        in2_d       = in2_q;
        in3_d       = in3_q;
`ifdef SHIFT_SER_CHECKSUM_EN
        chk_d       = chk_q;
`endif
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        frame_cnt_d = frame_cnt_q;
        frame_done  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Reset overrides this in the register stage, so IN_VALID alone suffices.
                if (IN_VALID) begin
                    in2_d       = IN2;
                    in3_d       = IN3;
`ifdef SHIFT_SER_CHECKSUM_EN
                    chk_d       = IN1 ^ IN2 ^ IN3;
`endif
                    out_valid_d = 1'b1;
                    out_data_d  = IN1;
                    state_d     = B0;
                end
            end
            B0: begin
                if (beat_xfer) begin
                    out_data_d = in2_q;
                    state_d    = B1;
                end
            end
            B1: begin
                if (beat_xfer) begin
                    out_data_d = in3_q;
                    state_d    = B2;
                end
            end
            B2: begin
                if (beat_xfer) begin
`ifdef SHIFT_SER_CHECKSUM_EN
                    out_data_d = chk_q;
                    state_d    = BCHK;
`else
                    frame_done = 1'b1;
`endif
                end
            end
`ifdef SHIFT_SER_CHECKSUM_EN
            BCHK: begin
                if (beat_xfer) begin
                    frame_done = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Last beat gone: drop valid with no gap cycle and count the frame.
        if (frame_done) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end

        // Index and last flag follow the state being entered, so they stay aligned with data.
        out_sel_d  = state_sel(state_d);
        out_last_d = (state_d == LAST_BEAT);
    end

    // FSM state and frame holding registers, synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            in2_q   <= '0;
            in3_q   <= '0;
`ifdef SHIFT_SER_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            in2_q   <= in2_d;
            in3_q   <= in3_d;
`ifdef SHIFT_SER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    // Registered outputs and frame counter; reset discards any frame in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= SEL_B0;
            out_last_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_last_q  <= out_last_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_shift_result_serializer.sv
// tb_shift_result_serializer: randomized self-checking bench for shift_result_serializer.
// Honours SHIFT_SER_CHECKSUM_EN the same way as the design (4-beat frames when defined).
module tb_shift_result_serializer;

`ifdef SHIFT_SER_CHECKSUM_EN
    localparam int BEATS = 4;
`else
    localparam int BEATS = 3;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [8:0] IN1 = '0;
    logic [8:0] IN2 = '0;
    logic [8:0] IN3 = '0;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b0;
    logic [8:0] OUT_DATA;
    logic [1:0] OUT_SEL;
    logic       OUT_LAST;
    logic [7:0] FRAME_CNT;

    typedef struct packed {
        logic [8:0] data;
        logic [1:0] sel;
        logic       last;
    } beat_t;

    beat_t      expq[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_cnt = '0;

    shift_result_serializer #(.WIDTH(8), .CNT_W(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN1       (IN1),
        .IN2       (IN2),
        .IN3       (IN3),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_SEL   (OUT_SEL),
        .OUT_LAST  (OUT_LAST),
        .FRAME_CNT (FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    // Reference: an accepted frame becomes an ordered list of beats.
    function automatic void model_frame(input logic [8:0] a, input logic [8:0] b,
                                        input logic [8:0] c);
        expq.push_back('{data: a, sel: 2'd0, last: 1'b0});
        expq.push_back('{data: b, sel: 2'd1, last: 1'b0});
`ifdef SHIFT_SER_CHECKSUM_EN
        expq.push_back('{data: c, sel: 2'd2, last: 1'b0});
        expq.push_back('{data: a ^ b ^ c, sel: 2'd3, last: 1'b1});
`else
        expq.push_back('{data: c, sel: 2'd2, last: 1'b1});
`endif
    endfunction

    task automatic test_reset();
        RST = 1'b1; IN_VALID = 1'b1; OUT_READY = 1'b1;
        IN1 = 9'($urandom); IN2 = 9'($urandom); IN3 = 9'($urandom);
        repeat (2) begin
            @(negedge CLK);
            vectors++;
            if (IN_READY !== 1'b0 || OUT_VALID !== 1'b0 || FRAME_CNT !== 8'd0 ||
                OUT_DATA !== 9'd0 || OUT_SEL !== 2'd0 || OUT_LAST !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state ready=%b valid=%b cnt=%0d data=%h sel=%0d last=%b, required all 0",
                         IN_READY, OUT_VALID, FRAME_CNT, OUT_DATA, OUT_SEL, OUT_LAST);
            end
        end
        @(posedge CLK); #1;
        RST = 1'b0; IN_VALID = 1'b0;
        @(negedge CLK);
        vectors++;
        if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release ready=%b valid=%b, required ready=1 valid=0",
                     IN_READY, OUT_VALID);
        end
        exp_cnt = '0;
        expq.delete();
    endtask

    task automatic test_basic();
        beat_t got, exp;
        bit    accepted, started;
        accepted = 1'b0; started = 1'b0;
        @(posedge CLK); #1;
        IN1 = 9'h03F; IN2 = 9'h1F0; IN3 = 9'h178; IN_VALID = 1'b1; OUT_READY = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge CLK);
            if (started && expq.size() != 0) begin
                vectors++;
                if (OUT_VALID !== 1'b1) begin
                    miscompares++;
                    $display("FAIL basic_no_bubble cycle %0d valid=%b, required 1", cyc, OUT_VALID);
                end
            end
            if (IN_VALID && IN_READY === 1'b1) begin
                model_frame(IN1, IN2, IN3);
                accepted = 1'b1;
            end
            started = accepted;
            if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
                got = '{data: OUT_DATA, sel: OUT_SEL, last: OUT_LAST};
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("FAIL basic_beat got data=%h sel=%0d, required no beat", got.data, got.sel);
                end else begin
                    exp = expq.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL basic_beat data=%h sel=%0d last=%b, required data=%h sel=%0d last=%b",
                                 got.data, got.sel, got.last, exp.data, exp.sel, exp.last);
                    end
                    if (exp.last) exp_cnt++;
                end
            end
            @(posedge CLK); #1;
            if (accepted) IN_VALID = 1'b0;
            if (accepted && expq.size() == 0) break;
        end
        @(negedge CLK);
        vectors++;
        if (!accepted || expq.size() != 0 || OUT_VALID !== 1'b0 || FRAME_CNT !== exp_cnt) begin
            miscompares++;
            $display("FAIL basic_end accepted=%b left=%0d valid=%b cnt=%0d, required 1/0/0/%0d",
                     accepted, expq.size(), OUT_VALID, FRAME_CNT, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        beat_t got, exp;
        bit    accepted;
        int    stall;
        accepted = 1'b0; stall = 0;
        @(posedge CLK); #1;
        IN1 = 9'h03F; IN2 = 9'h1F0; IN3 = 9'h178; IN_VALID = 1'b1; OUT_READY = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge CLK);
            if (IN_VALID && IN_READY === 1'b1) begin
                model_frame(IN1, IN2, IN3);
                accepted = 1'b1;
            end
            if (OUT_VALID === 1'b1 && OUT_READY === 1'b0) begin
                stall++;
                vectors++;
                if (OUT_DATA !== 9'h1F0 || OUT_SEL !== 2'd1 || OUT_LAST !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_hold stall %0d data=%h sel=%0d last=%b, required data=1f0 sel=1 last=0",
                             stall, OUT_DATA, OUT_SEL, OUT_LAST);
                end
            end
            if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
                got = '{data: OUT_DATA, sel: OUT_SEL, last: OUT_LAST};
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("FAIL bp_beat got data=%h sel=%0d, required no beat", got.data, got.sel);
                end else begin
                    exp = expq.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL bp_beat data=%h sel=%0d last=%b, required data=%h sel=%0d last=%b",
                                 got.data, got.sel, got.last, exp.data, exp.sel, exp.last);
                    end
                    if (exp.last) exp_cnt++;
                end
            end
            @(posedge CLK); #1;
            if (accepted) IN_VALID = 1'b0;
            OUT_READY = !(OUT_VALID === 1'b1 && OUT_SEL == 2'd1 && stall < 3);
            if (accepted && expq.size() == 0) break;
        end
        OUT_READY = 1'b1;
        @(negedge CLK);
        vectors++;
        if (!accepted || expq.size() != 0 || OUT_VALID !== 1'b0 || FRAME_CNT !== exp_cnt) begin
            miscompares++;
            $display("FAIL bp_end accepted=%b left=%0d valid=%b cnt=%0d, required 1/0/0/%0d",
                     accepted, expq.size(), OUT_VALID, FRAME_CNT, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        beat_t got, exp;
        int    nacc;
        bit    f2_shown, acc_now;
        nacc = 0; f2_shown = 1'b0;
        @(posedge CLK); #1;
        IN1 = 9'($urandom); IN2 = 9'($urandom); IN3 = 9'($urandom);
        IN_VALID = 1'b1; OUT_READY = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge CLK);
            acc_now = 1'b0;
            if (OUT_VALID === 1'b1) begin
                vectors++;
                if (IN_READY !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_busy_ready cycle %0d ready=%b, required 0", cyc, IN_READY);
                end
            end
            if (IN_VALID && IN_READY === 1'b1) begin
                model_frame(IN1, IN2, IN3);
                nacc++;
                acc_now = 1'b1;
            end
            if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
                got = '{data: OUT_DATA, sel: OUT_SEL, last: OUT_LAST};
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_beat got data=%h sel=%0d, required no beat", got.data, got.sel);
                end else begin
                    exp = expq.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL b2b_beat data=%h sel=%0d last=%b, required data=%h sel=%0d last=%b",
                                 got.data, got.sel, got.last, exp.data, exp.sel, exp.last);
                    end
                    if (exp.last) exp_cnt++;
                end
            end
            @(posedge CLK); #1;
            if (acc_now) begin
                // Scramble inputs while busy: the frame registers must not follow them.
                IN_VALID = 1'b0;
                IN1 = 9'($urandom); IN2 = 9'($urandom); IN3 = 9'($urandom);
            end
            if (!f2_shown && nacc == 1 && OUT_VALID === 1'b1 && OUT_SEL == 2'd1) begin
                IN1 = 9'h001; IN2 = 9'($urandom); IN3 = 9'($urandom);
                IN_VALID = 1'b1;
                f2_shown = 1'b1;
            end
            if (nacc == 2 && expq.size() == 0) break;
        end
        @(negedge CLK);
        vectors++;
        if (nacc != 2 || expq.size() != 0 || FRAME_CNT !== exp_cnt) begin
            miscompares++;
            $display("FAIL b2b_end frames=%0d left=%0d cnt=%0d, required 2/0/%0d",
                     nacc, expq.size(), FRAME_CNT, exp_cnt);
        end
    endtask

    task automatic test_mid_reset();
        beat_t got, exp;
        bit    accepted, hit;
        hit = 1'b0;
        @(posedge CLK); #1;
        IN1 = 9'($urandom); IN2 = 9'($urandom); IN3 = 9'($urandom);
        IN_VALID = 1'b1; OUT_READY = 1'b1;
        for (int cyc = 0; cyc < 10 && !hit; cyc++) begin
            @(posedge CLK); #1;
            if (OUT_VALID === 1'b1) IN_VALID = 1'b0;
            hit = (OUT_VALID === 1'b1 && OUT_SEL == 2'd1);
        end
        RST = 1'b1;
        @(negedge CLK);
        vectors++;
        if (!hit || IN_READY !== 1'b0) begin
            miscompares++;
            $display("FAIL mreset_ready reached_beat1=%b ready=%b, required 1/0", hit, IN_READY);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        vectors++;
        if (OUT_VALID !== 1'b0 || FRAME_CNT !== 8'd0 || OUT_LAST !== 1'b0 || IN_READY !== 1'b1) begin
            miscompares++;
            $display("FAIL mreset_clear valid=%b cnt=%0d last=%b ready=%b, required 0/0/0/1",
                     OUT_VALID, FRAME_CNT, OUT_LAST, IN_READY);
        end
        expq.delete();
        exp_cnt = '0;
        accepted = 1'b0;
        @(posedge CLK); #1;
        IN1 = 9'($urandom); IN2 = 9'($urandom); IN3 = 9'($urandom); IN_VALID = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge CLK);
            if (IN_VALID && IN_READY === 1'b1) begin
                model_frame(IN1, IN2, IN3);
                accepted = 1'b1;
            end
            if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
                got = '{data: OUT_DATA, sel: OUT_SEL, last: OUT_LAST};
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("FAIL mreset_beat got data=%h sel=%0d, required no beat", got.data, got.sel);
                end else begin
                    exp = expq.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL mreset_beat data=%h sel=%0d last=%b, required data=%h sel=%0d last=%b",
                                 got.data, got.sel, got.last, exp.data, exp.sel, exp.last);
                    end
                    if (exp.last) exp_cnt++;
                end
            end
            @(posedge CLK); #1;
            if (accepted) IN_VALID = 1'b0;
            if (accepted && expq.size() == 0) break;
        end
        @(negedge CLK);
        vectors++;
        if (!accepted || expq.size() != 0 || FRAME_CNT !== exp_cnt) begin
            miscompares++;
            $display("FAIL mreset_end accepted=%b left=%0d cnt=%0d, required 1/0/%0d",
                     accepted, expq.size(), FRAME_CNT, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        beat_t got, exp;
        int    nacc, last_acc;
        bit    acc_now;
        nacc = 0; last_acc = -1;
        @(posedge CLK); #1;
        IN1 = 9'($urandom); IN2 = 9'($urandom); IN3 = 9'($urandom);
        IN_VALID = 1'b1; OUT_READY = 1'b1;
        for (int cyc = 0; cyc < 256 * (BEATS + 1) + 20; cyc++) begin
            @(negedge CLK);
            acc_now = 1'b0;
            vectors++;
            if (FRAME_CNT !== exp_cnt) begin
                miscompares++;
                $display("FAIL wrap_cnt cycle %0d cnt=%0d, required %0d", cyc, FRAME_CNT, exp_cnt);
            end
            if (IN_VALID && IN_READY === 1'b1) begin
                model_frame(IN1, IN2, IN3);
                nacc++;
                acc_now = 1'b1;
                if (last_acc >= 0) begin
                    vectors++;
                    if (cyc - last_acc != BEATS + 1) begin
                        miscompares++;
                        $display("FAIL wrap_period frame %0d period=%0d, required %0d",
                                 nacc, cyc - last_acc, BEATS + 1);
                    end
                end
                last_acc = cyc;
            end
            if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
                got = '{data: OUT_DATA, sel: OUT_SEL, last: OUT_LAST};
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("FAIL wrap_beat got data=%h sel=%0d, required no beat", got.data, got.sel);
                end else begin
                    exp = expq.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL wrap_beat data=%h sel=%0d last=%b, required data=%h sel=%0d last=%b",
                                 got.data, got.sel, got.last, exp.data, exp.sel, exp.last);
                    end
                    if (exp.last) exp_cnt++;
                end
            end
            @(posedge CLK); #1;
            if (acc_now) begin
                IN1 = 9'($urandom); IN2 = 9'($urandom); IN3 = 9'($urandom);
                if (nacc == 256) IN_VALID = 1'b0;
            end
            if (nacc == 256 && expq.size() == 0) break;
        end
        @(negedge CLK);
        vectors++;
        if (nacc != 256 || expq.size() != 0 || FRAME_CNT !== exp_cnt) begin
            miscompares++;
            $display("FAIL wrap_end frames=%0d left=%0d cnt=%0d, required 256/0/%0d",
                     nacc, expq.size(), FRAME_CNT, exp_cnt);
        end
    endtask

    task automatic test_random();
        beat_t got, exp, cur, held;
        int    sent;
        bit    acc_now, held_valid;
        sent = 0; held_valid = 1'b0;
        @(posedge CLK); #1;
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge CLK);
            acc_now = 1'b0;
            cur = '{data: OUT_DATA, sel: OUT_SEL, last: OUT_LAST};
            vectors++;
            if (FRAME_CNT !== exp_cnt) begin
                miscompares++;
                $display("FAIL random_cnt cycle %0d cnt=%0d, required %0d", cyc, FRAME_CNT, exp_cnt);
            end
            if (held_valid) begin
                vectors++;
                if (OUT_VALID !== 1'b1 || cur !== held) begin
                    miscompares++;
                    $display("FAIL random_hold valid=%b data=%h sel=%0d, required 1 data=%h sel=%0d",
                             OUT_VALID, cur.data, cur.sel, held.data, held.sel);
                end
            end
            held_valid = (OUT_VALID === 1'b1 && OUT_READY === 1'b0);
            held = cur;
            if (IN_VALID && IN_READY === 1'b1) begin
                model_frame(IN1, IN2, IN3);
                sent++;
                acc_now = 1'b1;
            end
            if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
                got = cur;
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("FAIL random_beat got data=%h sel=%0d, required no beat", got.data, got.sel);
                end else begin
                    exp = expq.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL random_beat data=%h sel=%0d last=%b, required data=%h sel=%0d last=%b",
                                 got.data, got.sel, got.last, exp.data, exp.sel, exp.last);
                    end
                    if (exp.last) exp_cnt++;
                end
            end
            @(posedge CLK); #1;
            if (acc_now) IN_VALID = 1'b0;
            // Upstream keeps an offered frame stable until it is taken.
            if (!IN_VALID && sent < 30 && $urandom_range(0, 1) == 1) begin
                IN1 = 9'($urandom); IN2 = 9'($urandom); IN3 = 9'($urandom);
                IN_VALID = 1'b1;
            end
            OUT_READY = ($urandom_range(0, 9) < 7);
            if (sent == 30 && !IN_VALID && expq.size() == 0) break;
        end
        vectors++;
        if (sent != 30 || expq.size() != 0) begin
            miscompares++;
            $display("FAIL random_end frames=%0d left=%0d, required 30/0", sent, expq.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
